mic_pdm_receiver: RTL
=====================

Name: mic_pdm_receiver

Overview:
Audio input path for the on-board PDM microphone. The block generates the microphone clock from the 50 MHz system clock and samples the 1-bit PDM stream. It decimates the stream into unsigned PCM samples by counting ones over a fixed window, and tracks a peak-hold/decay envelope. It raises sound_detected so the game logic can react to the player's voice or claps; it complements the tone/PWM audio output path.

Parameters:
CLK_DIV, 25, system cycles per micClk half-period (micClk = 50 MHz / (2*CLK_DIV) = 1 MHz)
DECIM, 64, PDM bits per PCM sample
SAMPLE_W, 7, width of sample/amplitude/envelope; must satisfy 2^SAMPLE_W > DECIM
DECAY_SAMPLES, 16, valid samples between envelope decrements
THRESH, 24, envelope level at or above which sound_detected = 1

Ports:
clock  in  1  system clock, 50 MHz, single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  1 = microphone running; 0 = idle and cleared
micData  in  1  PDM data from microphone
micClk  out  1  microphone clock
micLRSel  out  1  channel select, constant 0 (data valid at micClk rising edge)
sample  out  SAMPLE_W  ones count of last window, 0..DECIM
sample_valid  out  1  one-cycle strobe, new sample/amplitude
amplitude  out  SAMPLE_W  |2*sample - DECIM|
envelope  out  SAMPLE_W  peak-hold envelope of amplitude
sound_detected  out  1  envelope >= THRESH

Behaviour:
- Reset (synchronous, active-high; dominates enable): div counter=0, micClk=0, bit_cnt=0, acc=0, sample=0, amplitude=0, sample_valid=0, envelope=0, decay_cnt=0, sound_detected=0. micLRSel=0 always.
- enable=0: same clearing as reset for the divider, micClk, bit_cnt, acc and sample_valid. sample, amplitude, envelope and sound_detected hold their values.
- Divider: counts 0..CLK_DIV-1, wraps, and toggles micClk at CLK_DIV-1. Duty cycle is exactly 50%. First toggle (0->1) occurs CLK_DIV cycles after enable rises.
- Bit strobe: in the cycle where micClk toggles 1->0 (end of high phase), micData is sampled into the window.
- Window: acc accumulates sampled bits.
  - On the strobe with bit_cnt=DECIM-1: sample <= acc+bit, amplitude <= |2*(acc+bit)-DECIM|, acc <= 0, bit_cnt <= 0, and sample_valid = 1 in the next cycle for exactly one cycle.
  - The first bit of the next window is the following strobe. No bits are dropped or double-counted across window boundaries.
- Width rules: acc is SAMPLE_W bits and never exceeds DECIM. The amplitude computation uses SAMPLE_W+1-bit signed intermediates, with no overflow.
- Envelope: updated in the cycle sample_valid is high, using the new amplitude.
  - If amplitude > envelope: envelope <= amplitude, decay_cnt <= 0.
  - Else decay_cnt increments. When decay_cnt reaches DECAY_SAMPLES-1: decay_cnt <= 0 and envelope <= envelope-1, saturating at 0.
- sound_detected: registered. Updates one cycle after envelope changes, to (envelope >= THRESH).
- Latency from the final window bit strobe: sample/amplitude/valid +1 cycle, envelope +2 cycles, sound_detected +3 cycles.
- Reset or enable drop mid-window discards the partial window. No sample_valid is produced for it, and the next window after re-enable is a full DECIM bits.

Test Plan:
1. Reset, enable=1, micData=1 constant -> micClk period 50 cycles (25 high/25 low), first sample_valid ~3200 cycles after enable with sample=64, amplitude=64; envelope=64 two cycles after the last strobe; sound_detected=1 one cycle later.
2. micData alternating 1,0 per strobe -> every sample=32, amplitude=0, envelope stays 0, sound_detected=0; sample_valid strobes exactly 64 micClk periods apart, each 1 cycle wide.
3. Four loud windows (all 1s), then alternating pattern -> envelope holds 64, then drops by 1 every 16 samples. sound_detected falls one cycle after envelope reaches 23.
4. micData=0 for 10 bits, then 1 for 54 bits -> sample=54, amplitude=44; next window all 0s -> sample=0, amplitude=64, envelope=64.
5. Assert reset after 30 bits of a window -> all outputs 0 the next cycle, micClk=0. After release, the next sample_valid follows a full 64-bit window, with sample unaffected by the pre-reset bits.
6. Drop enable mid-window with envelope=40 -> micClk=0 and no sample_valid, envelope stays 40 and sound_detected stays 1. Re-enable -> a full fresh window follows.

Source files
------------

// File: rtl/mic_pdm_receiver_if.sv
// Signal bundle between the PDM microphone receiver and its user: control and
// microphone pins in, decimated samples and envelope/detection flags out.
`timescale 1ns/1ps
interface mic_pdm_receiver_if #(
   parameter int SAMPLE_W = 7
);
   logic                enable;
   logic                micData;
   logic                micClk;
   logic                micLRSel;
   logic [SAMPLE_W-1:0] sample;
   logic                sample_valid;
   logic [SAMPLE_W-1:0] amplitude;
   logic [SAMPLE_W-1:0] envelope;
   logic                sound_detected;

   modport master (
      output enable, micData,
      input  micClk, micLRSel, sample, sample_valid, amplitude, envelope, sound_detected
   );

   modport slave (
      input  enable, micData,
      output micClk, micLRSel, sample, sample_valid, amplitude, envelope, sound_detected
   );
endinterface

// File: rtl/mic_pdm_receiver.sv
// PDM microphone front end: generates micClk, counts ones per DECIM-bit window
// into a PCM sample, and tracks a peak-hold/decay envelope for sound detection.
`timescale 1ns/1ps
module mic_pdm_receiver #(
   parameter int CLK_DIV       = 25,
   parameter int DECIM         = 64,
   parameter int SAMPLE_W      = 7,
   parameter int DECAY_SAMPLES = 16,
   parameter int THRESH        = 24
) (
   input  logic              clock,
   input  logic              reset,
   mic_pdm_receiver_if.slave mic
);

   localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int DCW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

   localparam logic [DVW-1:0]      DIV_LAST   = DVW'(CLK_DIV - 1);
   localparam logic [BCW-1:0]      BIT_LAST   = BCW'(DECIM - 1);
   localparam logic [DCW-1:0]      DECAY_LAST = DCW'(DECAY_SAMPLES - 1);
   localparam logic [SAMPLE_W-1:0] THRESH_V   = SAMPLE_W'(THRESH);

   // |2*s - DECIM| in SAMPLE_W+1 signed bits; the doubled term may wrap, but the
   // true difference lies within +/-DECIM so the modular result is exact.
   function automatic logic [SAMPLE_W-1:0] abs_offset(input logic [SAMPLE_W-1:0] s);
      logic signed [SAMPLE_W:0] dbl;
      logic signed [SAMPLE_W:0] diff;
      dbl  = $signed({s, 1'b0});
      diff = dbl - $signed((SAMPLE_W+1)'(DECIM));
      if (diff[SAMPLE_W]) diff = -diff;
      return diff[SAMPLE_W-1:0];
   endfunction

   function automatic logic [SAMPLE_W-1:0] sat_dec(input logic [SAMPLE_W-1:0] v);
      return (v == '0) ? v : v - SAMPLE_W'(1);
   endfunction

   logic [DVW-1:0]      div_cnt;
   logic                mic_clk;
   logic [BCW-1:0]      bit_cnt;
   logic [SAMPLE_W-1:0] acc;

   logic                div_wrap;
   logic                bit_stb_p0;
   logic                win_end_p0;
   logic [SAMPLE_W-1:0] acc_next_p0;

   logic [SAMPLE_W-1:0] sample_p1;
   logic [SAMPLE_W-1:0] amplitude_p1;
   logic                vld_p1;

   logic [SAMPLE_W-1:0] envelope_p2;
   logic [DCW-1:0]      decay_cnt;

   logic                sound_p3;

   // Stage p0: bit strobe at the end of the micClk high phase
   always_comb begin
      div_wrap    = mic.enable && (div_cnt == DIV_LAST);
      bit_stb_p0  = div_wrap && mic_clk;
      win_end_p0  = bit_stb_p0 && (bit_cnt == BIT_LAST);
      acc_next_p0 = acc + SAMPLE_W'(mic.micData);
   end

   always_ff @(posedge clock) begin
      if (reset || !mic.enable) begin
         div_cnt <= '0;
         mic_clk <= 1'b0;
         bit_cnt <= '0;
         acc     <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= win_end_p0;
         if (div_wrap) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
         end else begin
            div_cnt <= div_cnt + DVW'(1);
         end
         if (bit_stb_p0) begin
            if (win_end_p0) begin
               bit_cnt <= '0;
               acc     <= '0;
            end else begin
               bit_cnt <= bit_cnt + BCW'(1);
               acc     <= acc_next_p0;
            end
         end
      end
   end

   // Stage p1: window result; sample/amplitude hold while idle
   always_ff @(posedge clock) begin
      if (reset) begin
         sample_p1    <= '0;
         amplitude_p1 <= '0;
      end else if (win_end_p0) begin
         sample_p1    <= acc_next_p0;
         amplitude_p1 <= abs_offset(acc_next_p0);
      end
   end

   // Stage p2: peak-hold envelope with slow linear decay
   always_ff @(posedge clock) begin
      if (reset) begin
         envelope_p2 <= '0;
         decay_cnt   <= '0;
      end else if (vld_p1) begin
         if (amplitude_p1 > envelope_p2) begin
            envelope_p2 <= amplitude_p1;
            decay_cnt   <= '0;
         end else if (decay_cnt == DECAY_LAST) begin
            envelope_p2 <= sat_dec(envelope_p2);
            decay_cnt   <= '0;
         end else begin
            decay_cnt <= decay_cnt + DCW'(1);
         end
      end
   end

   // Stage p3: detection flag follows the envelope one cycle later
   always_ff @(posedge clock) begin
      if (reset) begin
         sound_p3 <= 1'b0;
      end else begin
         sound_p3 <= (envelope_p2 >= THRESH_V);
      end
   end

   assign mic.micClk         = mic_clk;
   assign mic.micLRSel       = 1'b0;
   assign mic.sample         = sample_p1;
   assign mic.amplitude      = amplitude_p1;
   assign mic.sample_valid   = vld_p1;
   assign mic.envelope       = envelope_p2;
   assign mic.sound_detected = sound_p3;

endmodule
